// File: rtl/gpr_dump_reader_pkg.sv
// Shared definitions for the GPR dump reader.
//   GPR_ADDR_W   : width of a GPR register index / read-port address
//   GPR_NUM      : number of architectural registers
//   dump_state_t : dump sequencer state encoding (2-bit)
package gpr_dump_reader_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int GPR_NUM    = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/dump_xsum.sv
// XOR accumulator for the dump checksum.
// Ports:
//   clk   : clock
//   rst   : synchronous reset, active-low
//   clear : zero the accumulator (wins over en)
//   en    : fold din into the accumulator
//   din   : word to fold in
//   q     : running XOR
module dump_xsum
  import gpr_dump_reader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= q ^ din;
    end
  end

endmodule

// File: rtl/gpr_dump_reader.sv
// Sequential read-out engine for the GPR register file. Walks registers
// FIRST_REG..LAST_REG through one read port and streams {index, value}
// words over a valid/ready handshake, holding datapath writes off while
// the dump runs so the stream is a consistent snapshot.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start; read port parked at address 0
// READ   | read port addresses idx; capture word (or skip a zero)
// SEND   | word presented on out_*; waits for out_ready
// DONE   | one-cycle done pulse, xsum final
//
// Ports:
//   clk, rst          : clock; synchronous active-low reset
//   start             : dump request, sampled only in IDLE
//   busy / wr_hold    : high from READ entry until DONE is left
//   done              : one-cycle pulse in DONE
//   rd_addr / rd_data : GPR read port (rd_data combinational on rd_addr)
//   out_valid/out_ready, out_idx, out_data, out_last : output stream
//   xsum              : XOR of words emitted in the current/last dump
module gpr_dump_reader
  import gpr_dump_reader_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter int SKIP_ZERO = 0,
  parameter int DATA_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_hold,
  output logic [GPR_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [GPR_ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic [DATA_W-1:0]     xsum
);

  localparam logic [GPR_ADDR_W-1:0] FIRST_IDX = GPR_ADDR_W'(FIRST_REG);
  localparam logic [GPR_ADDR_W-1:0] LAST_IDX  = GPR_ADDR_W'(LAST_REG);

  dump_state_t           state, state_nxt;
  logic [GPR_ADDR_W-1:0] idx;
  logic                  rd_skip;
  logic                  accept;
  logic                  xsum_clear;

  // LAST_REG is never skipped so every dump ends with an out_last word.
  assign rd_skip = (SKIP_ZERO != 0) && (rd_data == '0) && (idx != LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    out_valid  = 1'b0;
    rd_addr    = '0;
    accept     = 1'b0;
    xsum_clear = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          xsum_clear = 1'b1;
          state_nxt  = S_READ;
        end
      end
      S_READ: begin
        busy    = 1'b1;
        rd_addr = idx;
        if (!rd_skip) begin
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        rd_addr   = idx;
        if (out_ready) begin
          accept    = 1'b1;
          state_nxt = out_last ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign wr_hold = busy;

  // Index counter and output word register. The word is captured in READ
  // and left untouched through SEND, which keeps it stable under backpressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx      <= FIRST_IDX;
      out_idx  <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx <= FIRST_IDX;
          end
        end
        S_READ: begin
          out_data <= rd_data;
          out_idx  <= idx;
          out_last <= (idx == LAST_IDX);
          if (rd_skip) begin
            idx <= idx + 1'b1;
          end
        end
        S_SEND: begin
          if (out_ready && !out_last) begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  dump_xsum #(
    .DATA_W(DATA_W)
  ) u_xsum (
    .clk  (clk),
    .rst  (rst),
    .clear(xsum_clear),
    .en   (accept),
    .din  (out_data),
    .q    (xsum)
  );

endmodule

// File: tb/tb_gpr_dump_reader.sv
// Bench for gpr_dump_reader: two instances (SKIP_ZERO 0 and 1) share a GPR
// array model. Expected words are computed from the register contents when
// a dump starts and queued; a monitor pops and compares on each handshake.
module tb_gpr_dump_reader;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] gpr [32];

  logic        start     [2];
  logic        rst_v     [2];
  logic        rdy       [2];
  logic        busy      [2];
  logic        done      [2];
  logic        wr_hold   [2];
  logic [4:0]  rd_addr   [2];
  logic [31:0] rd_data   [2];
  logic        out_valid [2];
  logic [4:0]  out_idx   [2];
  logic [31:0] out_data  [2];
  logic        out_last  [2];
  logic [31:0] xsum      [2];

  word_t       exp_q    [2][$];
  logic [31:0] exp_xsum [2];
  int          done_cnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gpr_dump_reader #(
      .FIRST_REG(0),
      .LAST_REG (31),
      .SKIP_ZERO(g),
      .DATA_W   (32)
    ) u_dut (
      .clk      (clk),
      .rst      (rst_v[g]),
      .start    (start[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .wr_hold  (wr_hold[g]),
      .rd_addr  (rd_addr[g]),
      .rd_data  (rd_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(rdy[g]),
      .out_idx  (out_idx[g]),
      .out_data (out_data[g]),
      .out_last (out_last[g]),
      .xsum     (xsum[g])
    );
    assign rd_data[g] = gpr[rd_addr[g]];
  end

  // Reference: every register in range, in order; with zero-skip, zero
  // registers drop out except the last one.
  function automatic void build_expect(input int g);
    word_t w;
    logic [31:0] x;
    x = '0;
    exp_q[g].delete();
    for (int i = 0; i < 32; i++) begin
      if (g == 0 || gpr[i] != 0 || i == 31) begin
        w.idx  = 5'(i);
        w.data = gpr[i];
        w.last = (i == 31);
        exp_q[g].push_back(w);
        x = x ^ gpr[i];
      end
    end
    exp_xsum[g] = x;
  endfunction

  // Monitor
  logic [4:0]  h_idx  [2];
  logic [31:0] h_data [2];
  logic        h_last [2];
  bit          h_v    [2];
  bit          p_done [2];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (wr_hold[g] !== busy[g]) begin
        errors++;
        $display("FAIL wr_hold_eq_busy[%0d] wr_hold=%b busy=%b", g, wr_hold[g], busy[g]);
      end
      if (!rst_v[g]) begin
        h_v[g]    = 0;
        p_done[g] = 0;
      end else begin
        if (h_v[g]) begin
          checks++;
          if (!out_valid[g] || out_idx[g] !== h_idx[g] || out_data[g] !== h_data[g] ||
              out_last[g] !== h_last[g]) begin
            errors++;
            $display("FAIL hold_stable[%0d] got v=%b idx=%0d data=%h last=%b want v=1 idx=%0d data=%h last=%b",
                     g, out_valid[g], out_idx[g], out_data[g], out_last[g], h_idx[g], h_data[g], h_last[g]);
          end
        end
        h_v[g]    = out_valid[g] && !rdy[g];
        h_idx[g]  = out_idx[g];
        h_data[g] = out_data[g];
        h_last[g] = out_last[g];
        if (out_valid[g] && rdy[g]) begin
          checks++;
          if (exp_q[g].size() == 0) begin
            errors++;
            $display("FAIL unexpected_word[%0d] got idx=%0d data=%h want none", g, out_idx[g], out_data[g]);
          end else begin
            word_t w;
            w = exp_q[g].pop_front();
            if ({out_idx[g], out_data[g], out_last[g]} !== w) begin
              errors++;
              $display("FAIL word[%0d] got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                       g, out_idx[g], out_data[g], out_last[g], w.idx, w.data, w.last);
            end
          end
        end
        if (done[g]) begin
          done_cnt[g]++;
          checks++;
          if (xsum[g] !== exp_xsum[g]) begin
            errors++;
            $display("FAIL xsum[%0d] got %h want %h", g, xsum[g], exp_xsum[g]);
          end
          checks++;
          if (p_done[g] || exp_q[g].size() != 0) begin
            errors++;
            $display("FAIL done_pulse[%0d] prev_done=%b words_left=%0d want 0/0", g, p_done[g], exp_q[g].size());
          end
        end
        p_done[g] = done[g];
      end
    end
  end

  task automatic write_gprs(input bit rnd);
    @(posedge clk);
    #1;
    checks++;
    if (wr_hold[0] || wr_hold[1]) begin
      errors++;
      $display("FAIL gpr_wr_while_hold got wr_hold=%b%b want 00", wr_hold[0], wr_hold[1]);
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (rnd) gpr[i] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
        else gpr[i] = 32'h0;
      end
      if (!rnd) begin
        gpr[1] = 32'h8000_0001;
        gpr[2] = 32'h8000_0000;
      end
    end
  endtask

  // mode: 0 ready=1, 1 random ready, 2 stall idx2 for 5 cycles,
  //       3 extra start at cycle 10, 4 reset during SEND of idx5
  task automatic run_dump(input int g, input int mode, input int exp_lat, input int exp_first);
    int c0, rel, first_v, done_rel, stalls, dc0;
    bit stop;
    build_expect(g);
    dc0 = done_cnt[g];
    stop = 0; first_v = -1; done_rel = -1; stalls = 0;
    @(posedge clk); #1 start[g] = 1'b1; c0 = cyc;
    @(posedge clk); #1 start[g] = 1'b0;
    for (int n = 0; n < 400 && !stop; n++) begin
      rel = cyc - c0;
      case (mode)
        1: rdy[g] = ($urandom_range(0, 3) != 0);
        2: rdy[g] = !(rel >= 6 && rel <= 10);
        3: begin
          start[g] = (rel == 10);
          if (rel == 20) begin
            checks++;
            if (!wr_hold[g]) begin
              errors++;
              $display("FAIL wr_hold_mid_dump got %b want 1", wr_hold[g]);
            end
          end
        end
        4: begin
          if (rel == 12) begin rdy[g] = 1'b0; rst_v[g] = 1'b0; end
          else if (rel == 13) begin rst_v[g] = 1'b1; rdy[g] = 1'b1; exp_q[g].delete(); end
        end
        default: ;
      endcase
      @(negedge clk);
      if (rel == 1) begin
        checks++;
        if (busy[g] !== 1'b1) begin
          errors++;
          $display("FAIL busy_after_start got %b want 1", busy[g]);
        end
      end
      if (out_valid[g] && first_v < 0) first_v = rel;
      if (mode == 2 && out_valid[g] && !rdy[g] && out_idx[g] == 5'd2) stalls++;
      if (mode == 4 && rel == 12) begin
        checks++;
        if (!(out_valid[g] && out_idx[g] == 5'd5)) begin
          errors++;
          $display("FAIL pre_reset got valid=%b idx=%0d want valid=1 idx=5", out_valid[g], out_idx[g]);
        end
      end
      if (mode == 4 && rel == 13) begin
        checks++;
        if (busy[g] || out_valid[g] || done[g] || xsum[g] != 0) begin
          errors++;
          $display("FAIL after_reset got busy=%b valid=%b done=%b xsum=%h want 0 0 0 0",
                   busy[g], out_valid[g], done[g], xsum[g]);
        end
        stop = 1;
      end
      if (done[g]) begin done_rel = rel; stop = 1; end
      @(posedge clk); #1;
    end
    if (mode != 4) begin
      checks++;
      if (done_rel < 0) begin
        errors++;
        $display("FAIL done_timeout[%0d] got no done want done", g);
      end else if (exp_lat > 0) begin
        checks++;
        if (done_rel != exp_lat || first_v != exp_first) begin
          errors++;
          $display("FAIL latency[%0d] got done=%0d first_valid=%0d want %0d %0d",
                   g, done_rel, first_v, exp_lat, exp_first);
        end
      end
    end
    if (mode == 2) begin
      checks++;
      if (stalls != 5) begin
        errors++;
        $display("FAIL stall_cycles got %0d want 5", stalls);
      end
    end
    if (mode == 3) begin
      repeat (8) @(negedge clk);
      checks++;
      if (done_cnt[g] - dc0 != 1) begin
        errors++;
        $display("FAIL single_done got %0d want 1", done_cnt[g] - dc0);
      end
    end
    start[g] = 1'b0;
    rdy[g]   = 1'b1;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; rst_v[g] = 1'b0; rdy[g] = 1'b1;
      done_cnt[g] = 0; exp_xsum[g] = '0; h_v[g] = 0; p_done[g] = 0;
    end
    for (int i = 0; i < 32; i++) gpr[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (busy[g] || done[g] || wr_hold[g] || out_valid[g] || out_last[g] ||
          out_idx[g] != 0 || out_data[g] != 0 || xsum[g] != 0 || rd_addr[g] != 0) begin
        errors++;
        $display("FAIL reset_state[%0d] got busy=%b done=%b valid=%b last=%b idx=%0d data=%h xsum=%h addr=%0d want all 0",
                 g, busy[g], done[g], out_valid[g], out_last[g], out_idx[g], out_data[g], xsum[g], rd_addr[g]);
      end
    end

    write_gprs(0);
    run_dump(0, 0, 65, 2);
    run_dump(1, 0, 36, 3);
    run_dump(0, 2, 70, 2);
    run_dump(0, 3, 65, 2);
    run_dump(0, 4, 0, 0);
    run_dump(0, 0, 65, 2);

    for (int it = 0; it < 6; it++) begin
      write_gprs(1);
      run_dump(0, 1, 0, 0);
      run_dump(1, 1, 0, 0);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

endmodule
